// File: rtl/jk_sequencer_if.sv
// Command channel into jk_sequencer: valid/ready handshake carrying op, bit mask and repeat length.
interface jk_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             valid;
    logic             ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] mask;
    logic [CNT_W-1:0] len;

    modport master (output valid, op, mask, len, input ready);
    modport slave  (input valid, op, mask, len, output ready);
endinterface

// File: rtl/jk_sequencer.sv
// Command sequencer driving the J/K lines of an external JK flip-flop bank.
// Optional feature: define JK_SEQ_ABORT_EN to add an abort input that ends DRIVE early.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | cmd_ready=1, j=k=0, waiting for a command
// DRIVE | j/k decoded from latched op/mask (and q for COUNT), cnt counts down
// DONE  | one-cycle done pulse, j=k=0, back to IDLE
module jk_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    jk_sequencer_if.slave    cmd,
`ifdef JK_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_DONE} state_e;
    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_CLEAR  = 3'd1,
        OP_SET    = 3'd2,
        OP_LOAD   = 3'd3,
        OP_TOGGLE = 3'd4,
        OP_COUNT  = 3'd5
    } op_e;

    state_e           state;
    op_e              op_r;
    logic [WIDTH-1:0] mask_r;
    logic [CNT_W-1:0] cnt;
    logic             ready_r;
    logic             stop_drive;
    logic             carry;

    assign cmd.ready = ready_r;

`ifdef JK_SEQ_ABORT_EN
    assign stop_drive = (cnt == '0) || abort;
`else
    assign stop_drive = (cnt == '0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            op_r    <= OP_NOP;
            mask_r  <= '0;
            cnt     <= '0;
            ready_r <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd.valid && ready_r) begin
                        op_r   <= op_e'(cmd.op);
                        mask_r <= cmd.mask;
                        cnt    <= '0;
                        case (cmd.op)
                            OP_NOP: begin
                                state   <= ST_DONE;
                                ready_r <= 1'b0;
                                busy    <= 1'b1;
                                done    <= 1'b1;
                            end
                            OP_CLEAR, OP_SET, OP_LOAD: begin
                                state   <= ST_DRIVE;
                                ready_r <= 1'b0;
                                busy    <= 1'b1;
                            end
                            OP_TOGGLE, OP_COUNT: begin
                                state   <= ST_DRIVE;
                                ready_r <= 1'b0;
                                busy    <= 1'b1;
                                cnt     <= cmd.len;
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end
                ST_DRIVE: begin
                    if (stop_drive) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    ready_r <= 1'b1;
                    busy    <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_r <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // j/k depend only on registered state plus q, so cmd_* never reaches the bank directly.
    always_comb begin
        j     = '0;
        k     = '0;
        carry = 1'b1;
        if (state == ST_DRIVE) begin
            case (op_r)
                OP_CLEAR: k = mask_r;
                OP_SET:   j = mask_r;
                OP_LOAD: begin
                    j = mask_r;
                    k = ~mask_r;
                end
                OP_TOGGLE: begin
                    j = mask_r;
                    k = mask_r;
                end
                OP_COUNT: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        j[i] = mask_r[i] & carry;
                        k[i] = mask_r[i] & carry;
                        if (mask_r[i]) carry = carry & q[i];
                    end
                end
                default: begin
                    j = '0;
                    k = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_sequencer.sv
// Bench for jk_sequencer: a 4-bit JK bank model closes the q loop; a table of commands feeds a scoreboard.
module tb_jk_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] j, k;
    logic       busy, done, err;
    logic [3:0] bank_q;
    logic       bank_clr;
`ifdef JK_SEQ_ABORT_EN
    logic       abort;
`endif

    jk_sequencer_if #(.WIDTH(4), .CNT_W(8)) cmd_bus ();

    jk_sequencer #(.WIDTH(4), .CNT_W(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .cmd  (cmd_bus),
`ifdef JK_SEQ_ABORT_EN
        .abort(abort),
`endif
        .q    (bank_q),
        .j    (j),
        .k    (k),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    always #5 clk = ~clk;

    // Bank of four JK flip-flops: 00 hold, 01 reset, 10 set, 11 toggle.
    always @(posedge clk) begin
        if (bank_clr) bank_q <= 4'b0000;
        else begin
            for (int b = 0; b < 4; b++) begin
                case ({j[b], k[b]})
                    2'b01:   bank_q[b] <= 1'b0;
                    2'b10:   bank_q[b] <= 1'b1;
                    2'b11:   bank_q[b] <= ~bank_q[b];
                    default: bank_q[b] <= bank_q[b];
                endcase
            end
        end
    end

    typedef struct {
        logic [2:0] op;
        logic [3:0] mask;
        logic [7:0] len;
        logic [3:0] exp_j;
        logic [3:0] exp_k;
        int         cycles;
        logic       is_err;
        logic [3:0] exp_q;
    } vec_t;

    vec_t vecs[14];
    vec_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   drv_cnt = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: checks first-cycle drive, counts drive cycles, pops on done/err.
    always @(negedge clk) begin
        if (!mon_en) drv_cnt = 0;
        else begin
            if (!busy || done) chk("jk_quiet_outside_drive", {j, k}, 8'h00);
            if (busy && !done) begin
                if (drv_cnt == 0) begin
                    if (sb.size() == 0) chk("unexpected_drive", 32'd1, 32'd0);
                    else begin
                        chk("first_j", {28'd0, j}, {28'd0, sb[0].exp_j});
                        chk("first_k", {28'd0, k}, {28'd0, sb[0].exp_k});
                    end
                end
                drv_cnt++;
            end
            if (done || err) begin
                if (sb.size() == 0) chk("unexpected_done_or_err", 32'd1, 32'd0);
                else begin
                    vec_t e;
                    e = sb.pop_front();
                    chk("drive_cycles", drv_cnt, e.cycles);
                    chk("err_flag", {31'd0, err}, {31'd0, e.is_err});
                    chk("done_flag", {31'd0, done}, {31'd0, ~e.is_err});
                    chk("bank_q", {28'd0, bank_q}, {28'd0, e.exp_q});
                end
                drv_cnt = 0;
            end
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        while ((sb.size() != 0 || !cmd_bus.ready) && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic send(input vec_t v);
        @(negedge clk);
        cmd_bus.valid = 1'b1;
        cmd_bus.op    = v.op;
        cmd_bus.mask  = v.mask;
        cmd_bus.len   = v.len;
        sb.push_back(v);
        @(posedge clk);
        #1 cmd_bus.valid = 1'b0;
        @(negedge clk);
        chk("busy_after_accept", {31'd0, busy}, {31'd0, ~v.is_err});
        wait_idle();
    endtask

    initial begin
        int dones;
        vec_t v;
        rst = 1'b1;
        bank_clr = 1'b1;
        cmd_bus.valid = 1'b0;
        cmd_bus.op = 3'd0;
        cmd_bus.mask = 4'd0;
        cmd_bus.len = 8'd0;
`ifdef JK_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        vecs[0]  = '{3'd2, 4'b1010, 8'd0,   4'b1010, 4'b0000, 1,   1'b0, 4'b1010};
        vecs[1]  = '{3'd1, 4'b1010, 8'd0,   4'b0000, 4'b1010, 1,   1'b0, 4'b0000};
        vecs[2]  = '{3'd5, 4'b1111, 8'd5,   4'b0001, 4'b0001, 6,   1'b0, 4'b0110};
        vecs[3]  = '{3'd3, 4'b1010, 8'd0,   4'b1010, 4'b0101, 1,   1'b0, 4'b1010};
        vecs[4]  = '{3'd4, 4'b0011, 8'd2,   4'b0011, 4'b0011, 3,   1'b0, 4'b1001};
        vecs[5]  = '{3'd3, 4'b1111, 8'd0,   4'b1111, 4'b0000, 1,   1'b0, 4'b1111};
        vecs[6]  = '{3'd5, 4'b1111, 8'd0,   4'b1111, 4'b1111, 1,   1'b0, 4'b0000};
        vecs[7]  = '{3'd7, 4'b1111, 8'd0,   4'b0000, 4'b0000, 0,   1'b1, 4'b0000};
        vecs[8]  = '{3'd0, 4'b1111, 8'd3,   4'b0000, 4'b0000, 0,   1'b0, 4'b0000};
        vecs[9]  = '{3'd5, 4'b0101, 8'd2,   4'b0001, 4'b0001, 3,   1'b0, 4'b0101};
        vecs[10] = '{3'd6, 4'b0000, 8'd0,   4'b0000, 4'b0000, 0,   1'b1, 4'b0101};
        vecs[11] = '{3'd4, 4'b0000, 8'd0,   4'b0000, 4'b0000, 1,   1'b0, 4'b0101};
        vecs[12] = '{3'd5, 4'b0001, 8'd255, 4'b0001, 4'b0001, 256, 1'b0, 4'b0101};
        vecs[13] = '{3'd1, 4'b1111, 8'd0,   4'b0000, 4'b1111, 1,   1'b0, 4'b0000};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bank_clr = 1'b0;
        @(negedge clk);
        chk("reset_ready", {31'd0, cmd_bus.ready}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_jk", {24'd0, j, k}, 32'd0);
        chk("reset_done_err", {30'd0, done, err}, 32'd0);
        mon_en = 1'b1;

        for (int i = 0; i < 14; i++) send(vecs[i]);

        // Valid held through busy: ready must stay low for DRIVE and DONE, high the cycle after.
        v = '{3'd2, 4'b0001, 8'd0, 4'b0001, 4'b0000, 1, 1'b0, 4'b0001};
        @(negedge clk);
        cmd_bus.valid = 1'b1;
        cmd_bus.op = v.op;
        cmd_bus.mask = v.mask;
        cmd_bus.len = v.len;
        sb.push_back(v);
        @(posedge clk);
        #1 cmd_bus.op = 3'd1;
        cmd_bus.mask = 4'b1111;
        @(negedge clk);
        chk("b2b_ready_in_drive", {31'd0, cmd_bus.ready}, 32'd0);
        @(negedge clk);
        chk("b2b_ready_in_done", {30'd0, cmd_bus.ready, done}, 32'd1);
        @(negedge clk);
        chk("b2b_ready_after_done", {30'd0, cmd_bus.ready, busy}, 32'd2);
        cmd_bus.valid = 1'b0;
        wait_idle();

        // Reset on the 3rd drive cycle of COUNT len=9 from q=0001.
        mon_en = 1'b0;
        @(negedge clk);
        cmd_bus.valid = 1'b1;
        cmd_bus.op = 3'd5;
        cmd_bus.mask = 4'b1111;
        cmd_bus.len = 8'd9;
        @(posedge clk);
        #1 cmd_bus.valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_before_reset", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_abort_jk", {24'd0, j, k}, 32'd0);
        chk("rst_abort_ready_busy", {30'd0, cmd_bus.ready, busy}, 32'd2);
        chk("rst_abort_q", {28'd0, bank_q}, 32'h4);
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("rst_abort_no_done", dones, 0);
        mon_en = 1'b1;

`ifdef JK_SEQ_ABORT_EN
        // Abort on the 3rd drive cycle from q=0100: three counts then a normal done.
        v = '{3'd5, 4'b1111, 8'd9, 4'b0001, 4'b0001, 3, 1'b0, 4'b0111};
        @(negedge clk);
        cmd_bus.valid = 1'b1;
        cmd_bus.op = v.op;
        cmd_bus.mask = v.mask;
        cmd_bus.len = v.len;
        sb.push_back(v);
        @(posedge clk);
        #1 cmd_bus.valid = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_jk", {24'd0, j, k}, 32'd0);
        wait_idle();
`endif

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
